// File: rtl/arb8_rr.sv
// Eight-way round-robin arbiter for a shared mux8 path. Grants one requester at a
// time, caps each tenure at MAX_HOLD cycles and leaves one idle cycle between tenures.
module arb8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] CNT_LAST = 5'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] owner, owner_n;
    logic [4:0] cnt, cnt_n;
    logic [7:0] grant_n;
    logic       timeout_n;

    // First set request bit at or after start, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            owner   <= 3'd0;
            cnt     <= 5'd0;
            grant   <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            cnt     <= cnt_n;
            grant   <= grant_n;
            timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        cnt_n     = cnt;
        grant_n   = grant;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (req != 8'd0) begin
                    owner_n = rr_pick(req, ptr);
                    grant_n = 8'd1 << owner_n;
                    cnt_n   = 5'd0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                // Release (normal or forced) always passes through IDLE, giving the dead cycle.
                if (!req[owner] || cnt == CNT_LAST) begin
                    grant_n   = 8'd0;
                    ptr_n     = owner + 3'd1;
                    state_n   = IDLE;
                    timeout_n = req[owner];
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // sel only moves with owner, which only changes on the IDLE->BUSY edge.
    assign sel  = owner;
    assign busy = |grant;

endmodule

// File: tb/tb_arb8_rr.sv
// Scoreboard bench for arb8_rr: a tenure-level reference model queues expected outputs
// per clock edge, and a negedge monitor compares them against the DUT.
module tb_arb8_rr;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'hFF;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    arb8_rr #(.MAX_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant), .sel(sel), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       timeout;
    } exp_t;

    exp_t sb[$];
    int   dut_log[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: who holds the path, for how many cycles, and where the scan starts.
    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_len   = 0;
    logic [2:0] m_sel   = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_len   = 0;
        m_sel   = 3'd0;
        sb.delete();
    endfunction

    function automatic void model_edge(input logic [7:0] r);
        exp_t e;
        logic to;
        to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (m_len == HOLD) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                to      = 1'b1;
            end else begin
                m_len++;
            end
        end else if (r != 8'd0) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
            end
            m_len = 1;
            m_sel = 3'(m_owner);
        end
        e.grant   = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.sel     = m_sel;
        e.timeout = to;
        sb.push_back(e);
    endfunction

    // Apply r for one edge, then advance the model for that edge.
    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    // Reset asserted and released away from clock edges; outputs must clear immediately.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_grant", grant, 8'd0);
        check("rst_sel", sel, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    logic [7:0] prev_grant = 8'd0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_grant <= 8'd0;
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("grant", grant, e.grant);
                check("sel", sel, e.sel);
                check("timeout", timeout, e.timeout);
                check("busy", busy, |e.grant);
            end
            if (grant != 8'd0 && prev_grant == 8'd0) dut_log.push_back(int'(sel));
            prev_grant <= grant;
        end
    end

    initial begin
        logic [7:0] r;

        // Reset held with all requests pending: nothing may be granted.
        req = 8'hFF;
        repeat (2) @(posedge clk);
        #2;
        check("hold_rst_grant", grant, 8'd0);
        check("hold_rst_sel", sel, 3'd0);
        check("hold_rst_busy", busy, 1'b0);
        req = 8'h00;
        #1 rst = 1'b0;
        model_reset();
        repeat (5) step(8'h00);

        // Single requester 5 for four cycles.
        repeat (4) step(8'h20);
        repeat (3) step(8'h00);

        // Rotation from a fresh pointer: each owner drops after two granted cycles.
        do_reset();
        dut_log.delete();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF);
            step(8'hFF);
            step(8'hFF & ~(8'd1 << (i % 8)));
        end
        #5;
        check("rot_count", dut_log.size(), 9);
        for (int i = 0; i < 9 && i < dut_log.size(); i++)
            check($sformatf("rot_owner%0d", i), dut_log[i], i % 8);

        // Wrap: 7 releases, pointer wraps to 0; then 7 alone is regranted.
        step(8'h80);
        step(8'h80);
        step(8'h01);
        step(8'h81);
        #5;
        check("wrap_to0", dut_log[$], 0);
        step(8'h80);
        step(8'h80);
        #5;
        check("wrap_to7", dut_log[$], 7);
        step(8'h00);
        step(8'h00);

        // Hold limit with two steady requesters.
        do_reset();
        dut_log.delete();
        repeat (16) step(8'h06);
        #5;
        check("hold_count", dut_log.size() >= 3, 1'b1);
        if (dut_log.size() >= 3) begin
            check("hold_first", dut_log[0], 1);
            check("hold_second", dut_log[1], 2);
            check("hold_third", dut_log[2], 1);
        end
        step(8'h00);
        step(8'h00);

        // Release coinciding with the hold limit is a normal release.
        repeat (HOLD) step(8'h10);
        step(8'h00);
        step(8'h00);

        // Reset mid-tenure of requester 3, then a full tenure after release.
        step(8'h08);
        step(8'h08);
        check("pre_rst_grant", grant, 8'h08);
        do_reset();
        repeat (HOLD + 3) step(8'h08);
        step(8'h00);

        // Randomised traffic, with owners occasionally dropping their request.
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) r[m_owner] = 1'b0;
            step(r);
        end
        step(8'h00);
        step(8'h00);
        #5;
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
